projectile_ctl: RTL and testbench

PROJECTILE_CTL -- requirements
Module: projectile_ctl

---
 rtl/projectile_ctl_if.sv | 27 ++
 rtl/projectile_ctl.sv | 193 +++++++++++++++++++
 tb/tb_projectile_ctl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/projectile_ctl_if.sv
// Launch/step/collision inputs and flight status outputs of the projectile controller.
interface projectile_ctl_if;
    logic [6:0]  wind;
    logic        fire;
    logic [10:0] start_x;
    logic [10:0] start_y;
    logic [11:0] vx0;
    logic [11:0] vy0;
    logic        frame_tick;
    logic        hit;
    logic [10:0] proj_x;
    logic [10:0] proj_y;
    logic        proj_active;
    logic        impact;
    logic [1:0]  impact_cause;
    logic        turn_done;

    modport slave (
        input  wind, fire, start_x, start_y, vx0, vy0, frame_tick, hit,
        output proj_x, proj_y, proj_active, impact, impact_cause, turn_done
    );

    modport master (
        output wind, fire, start_x, start_y, vx0, vy0, frame_tick, hit,
        input  proj_x, proj_y, proj_active, impact, impact_cause, turn_done
    );
endinterface

// File: rtl/projectile_ctl.sv
// Projectile flight controller: Q11.4 position, Q7.4 velocity, explicit Euler stepping with
// wind and gravity, prioritised termination, then one-cycle impact and turn_done pulses.
module projectile_ctl #(
    parameter int SCREEN_W   = 1024,
    parameter int GROUND_Y   = 700,
    parameter int GRAVITY    = 3,
    parameter int WIND_CALM  = 50,
    parameter int MAX_FRAMES = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    projectile_ctl_if.slave  bus
);
    localparam int FCW = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FLIGHT = 2'd1,
        S_IMPACT = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    function automatic logic signed [11:0] sat12(input logic signed [12:0] v);
        if (v > 13'sd2047) begin
            sat12 = 12'sd2047;
        end else if (v < -13'sd2048) begin
            sat12 = -12'sd2048;
        end else begin
            sat12 = v[11:0];
        end
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
        if (v > 17'sd32767) begin
            sat16 = 16'sd32767;
        end else if (v < -17'sd32768) begin
            sat16 = -16'sd32768;
        end else begin
            sat16 = v[15:0];
        end
    endfunction

    function automatic logic [10:0] clamp_pix(input logic signed [11:0] v, input int hi);
        if (v < 12'sd0) begin
            clamp_pix = 11'd0;
        end else if (int'(v) > hi) begin
            clamp_pix = 11'(hi);
        end else begin
            clamp_pix = v[10:0];
        end
    endfunction

    state_t                  state_q, state_d;
    logic signed [15:0]      x_q, x_d, y_q, y_d;
    logic signed [11:0]      vx_q, vx_d, vy_q, vy_d;
    logic [6:0]              wind_l_q, wind_l_d;
    logic [FCW-1:0]          frame_cnt_q, frame_cnt_d;
    logic [10:0]             proj_x_q, proj_x_d, proj_y_q, proj_y_d;
    logic                    active_q, active_d;
    logic                    impact_q, impact_d;
    logic [1:0]              cause_q, cause_d;
    logic                    turn_done_q, turn_done_d;

    logic signed [11:0]      x_int_s, y_int_s;
    logic signed [7:0]       wind_diff_s, wind_acc_s;
    logic                    term_s;
    logic [1:0]              term_cause_s;

    // Next-state, physics step and termination decision.
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        vx_d         = vx_q;
        vy_d         = vy_q;
        wind_l_d     = wind_l_q;
        frame_cnt_d  = frame_cnt_q;
        cause_d      = cause_q;
        impact_d     = 1'b0;
        turn_done_d  = 1'b0;
        term_s       = 1'b0;
        term_cause_s = 2'd0;

        x_int_s     = x_q[15:4];
        y_int_s     = y_q[15:4];
        wind_diff_s = $signed({1'b0, wind_l_q}) - $signed(8'(WIND_CALM));
        wind_acc_s  = wind_diff_s >>> 3;

        // Hit outranks every other cause and also suppresses a coincident step.
        if (bus.hit) begin
            term_s       = 1'b1;
            term_cause_s = 2'd1;
        end else if (int'(y_int_s) >= GROUND_Y) begin
            term_s       = 1'b1;
            term_cause_s = 2'd0;
        end else if ((x_int_s < 12'sd0) || (int'(x_int_s) >= SCREEN_W)) begin
            term_s       = 1'b1;
            term_cause_s = 2'd2;
        end else if (frame_cnt_q == FCW'(MAX_FRAMES)) begin
            term_s       = 1'b1;
            term_cause_s = 2'd3;
        end else begin
            term_s       = 1'b0;
            term_cause_s = 2'd0;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.fire) begin
                    x_d         = $signed({1'b0, bus.start_x, 4'b0000});
                    y_d         = $signed({1'b0, bus.start_y, 4'b0000});
                    vx_d        = $signed(bus.vx0);
                    vy_d        = $signed(bus.vy0);
                    wind_l_d    = bus.wind;
                    frame_cnt_d = '0;
                    cause_d     = 2'd0;
                    state_d     = S_FLIGHT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FLIGHT: begin
                if (term_s) begin
                    state_d  = S_IMPACT;
                    impact_d = 1'b1;
                    cause_d  = term_cause_s;
                end else if (bus.frame_tick) begin
                    x_d         = sat16(17'(x_q) + 17'(vx_q));
                    y_d         = sat16(17'(y_q) + 17'(vy_q));
                    vx_d        = sat12(13'(vx_q) + 13'(wind_acc_s));
                    vy_d        = sat12(13'(vy_q) + $signed(13'(GRAVITY)));
                    frame_cnt_d = frame_cnt_q + FCW'(1);
                end else begin
                    state_d = S_FLIGHT;
                end
            end
            S_IMPACT: begin
                state_d     = S_DONE;
                turn_done_d = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        proj_x_d = clamp_pix(x_d[15:4], SCREEN_W - 1);
        proj_y_d = clamp_pix(y_d[15:4], GROUND_Y);
        active_d = (state_d == S_FLIGHT);
    end

    // State, physics and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            x_q         <= 16'sd0;
            y_q         <= 16'sd0;
            vx_q        <= 12'sd0;
            vy_q        <= 12'sd0;
            wind_l_q    <= 7'd0;
            frame_cnt_q <= '0;
            proj_x_q    <= 11'd0;
            proj_y_q    <= 11'd0;
            active_q    <= 1'b0;
            impact_q    <= 1'b0;
            cause_q     <= 2'd0;
            turn_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            vx_q        <= vx_d;
            vy_q        <= vy_d;
            wind_l_q    <= wind_l_d;
            frame_cnt_q <= frame_cnt_d;
            proj_x_q    <= proj_x_d;
            proj_y_q    <= proj_y_d;
            active_q    <= active_d;
            impact_q    <= impact_d;
            cause_q     <= cause_d;
            turn_done_q <= turn_done_d;
        end
    end

    assign bus.proj_x       = proj_x_q;
    assign bus.proj_y       = proj_y_q;
    assign bus.proj_active  = active_q;
    assign bus.impact       = impact_q;
    assign bus.impact_cause = cause_q;
    assign bus.turn_done    = turn_done_q;
endmodule

// File: tb/tb_projectile_ctl.sv
// Directed bench for projectile_ctl: flight physics, termination causes, pulse timing and reset abort.
module tb_projectile_ctl;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   imp_cnt;
    int   td_cnt;
    int   imp_base;
    int   td_base;

    projectile_ctl_if bus ();

    projectile_ctl #(
        .SCREEN_W   (1024),
        .GROUND_Y   (700),
        .GRAVITY    (3),
        .WIND_CALM  (50),
        .MAX_FRAMES (12)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled away from the active edge.
    always @(negedge clk) begin
        if (bus.impact === 1'b1) imp_cnt++;
        if (bus.turn_done === 1'b1) td_cnt++;
    end

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [6:0] w, input logic [10:0] sx, input logic [10:0] sy,
                          input logic [11:0] vx, input logic [11:0] vy);
        bus.wind    = w;
        bus.start_x = sx;
        bus.start_y = sy;
        bus.vx0     = vx;
        bus.vy0     = vy;
        bus.fire    = 1'b1;
        step();
        bus.fire    = 1'b0;
    endtask

    task automatic tick();
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
    endtask

    task automatic end_by_hit();
        bus.hit = 1'b1;
        step();
        bus.hit = 1'b0;
        step();
        step();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        imp_cnt = 0;
        td_cnt = 0;
        rst_n = 1'b0;
        bus.wind = 7'd50;
        bus.fire = 1'b0;
        bus.start_x = 11'd0;
        bus.start_y = 11'd0;
        bus.vx0 = 12'd0;
        bus.vy0 = 12'd0;
        bus.frame_tick = 1'b0;
        bus.hit = 1'b0;
        step();
        step();
        check("rst_proj_x", 32'(bus.proj_x), 0);
        check("rst_proj_y", 32'(bus.proj_y), 0);
        check("rst_active", 32'(bus.proj_active), 0);
        check("rst_impact", 32'(bus.impact), 0);
        check("rst_cause", 32'(bus.impact_cause), 0);
        check("rst_turn_done", 32'(bus.turn_done), 0);
        rst_n = 1'b1;

        // Calm flight
        launch(7'd50, 11'd100, 11'd600, 12'd16, 12'd0);
        check("calm_active", 32'(bus.proj_active), 1);
        tick();
        check("calm_vx1", 32'(dut.vx_q), 16);
        tick();
        tick();
        check("calm_vx3", 32'(dut.vx_q), 16);
        check("calm_vy3", 32'(dut.vy_q), 9);
        check("calm_proj_x", 32'(bus.proj_x), 103);
        check("calm_proj_y", 32'(bus.proj_y), 600);
        end_by_hit();
        check("calm_end_idle", 32'(bus.proj_active), 0);

        // Max wind, wind sampled at fire and held
        launch(7'd100, 11'd500, 11'd600, 12'd0, 12'hFE0);
        bus.wind = 7'd0;
        tick();
        check("wind_vx1", 32'(dut.vx_q), 6);
        tick();
        check("wind_vx2", 32'(dut.vx_q), 12);
        tick();
        check("wind_vx3", 32'(dut.vx_q), 18);
        check("wind_x3", 32'(dut.x_q), 8018);
        tick();
        check("wind_x4", 32'(dut.x_q), 8036);
        check("wind_vy4", 32'(dut.vy_q), -20);
        end_by_hit();

        // Ground impact
        imp_base = imp_cnt;
        td_base = td_cnt;
        launch(7'd50, 11'd300, 11'd699, 12'd0, 12'd32);
        tick();
        check("gnd_y_reg", 32'(dut.y_q), 11216);
        check("gnd_no_impact_yet", 32'(bus.impact), 0);
        step();
        check("gnd_impact", 32'(bus.impact), 1);
        check("gnd_cause", 32'(bus.impact_cause), 0);
        check("gnd_active_off", 32'(bus.proj_active), 0);
        step();
        check("gnd_turn_done", 32'(bus.turn_done), 1);
        check("gnd_impact_off", 32'(bus.impact), 0);
        step();
        check("gnd_td_off", 32'(bus.turn_done), 0);
        check("gnd_proj_y", 32'(bus.proj_y), 700);
        check("gnd_cause_hold", 32'(bus.impact_cause), 0);
        tick();
        check("gnd_idle_tick", 32'(bus.proj_active), 0);
        check("gnd_imp_count", imp_cnt - imp_base, 1);
        check("gnd_td_count", td_cnt - td_base, 1);

        // Simultaneous hit and frame_tick
        launch(7'd50, 11'd200, 11'd300, 12'd16, 12'd0);
        tick();
        check("hit_pre_x", 32'(bus.proj_x), 201);
        imp_base = imp_cnt;
        td_base = td_cnt;
        bus.hit = 1'b1;
        bus.frame_tick = 1'b1;
        step();
        bus.hit = 1'b0;
        bus.frame_tick = 1'b0;
        check("hit_x_reg", 32'(dut.x_q), 3216);
        check("hit_y_reg", 32'(dut.y_q), 4800);
        check("hit_proj_x", 32'(bus.proj_x), 201);
        check("hit_impact", 32'(bus.impact), 1);
        check("hit_cause", 32'(bus.impact_cause), 1);
        for (int i = 0; i < 5; i++) step();
        check("hit_imp_count", imp_cnt - imp_base, 1);
        check("hit_td_count", td_cnt - td_base, 1);
        check("hit_cause_hold", 32'(bus.impact_cause), 1);

        // Out of bounds on the right edge
        launch(7'd50, 11'd1020, 11'd300, 12'd1024, 12'd0);
        check("oob_start_x", 32'(bus.proj_x), 1020);
        tick();
        check("oob_proj_x", 32'(bus.proj_x), 1023);
        step();
        check("oob_impact", 32'(bus.impact), 1);
        check("oob_cause", 32'(bus.impact_cause), 2);
        step();
        step();

        // Timeout after MAX_FRAMES ticks
        launch(7'd50, 11'd500, 11'd600, 12'd0, 12'hF80);
        for (int i = 0; i < 11; i++) tick();
        check("to_active_11", 32'(bus.proj_active), 1);
        tick();
        check("to_active_12", 32'(bus.proj_active), 1);
        step();
        check("to_impact", 32'(bus.impact), 1);
        check("to_cause", 32'(bus.impact_cause), 3);
        step();
        step();

        // fire ignored in flight, then reset mid-flight
        launch(7'd50, 11'd100, 11'd300, 12'd16, 12'd0);
        tick();
        bus.start_x = 11'd900;
        bus.fire = 1'b1;
        step();
        bus.fire = 1'b0;
        check("fire_ign_x", 32'(dut.x_q), 1616);
        check("fire_ign_active", 32'(bus.proj_active), 1);
        @(negedge clk);
        imp_base = imp_cnt;
        td_base = td_cnt;
        rst_n = 1'b0;
        #1;
        check("rst_mid_active", 32'(bus.proj_active), 0);
        check("rst_mid_proj_x", 32'(bus.proj_x), 0);
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("rst_mid_no_impact", imp_cnt - imp_base, 0);
        check("rst_mid_no_td", td_cnt - td_base, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        bus.start_x = 11'd42;
        bus.fire = 1'b1;
        step();
        bus.fire = 1'b0;
        check("post_rst_fire_active", 32'(bus.proj_active), 1);
        check("post_rst_fire_x", 32'(bus.proj_x), 42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
